// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES block sequencer.
// Optional core watchdog is enabled by defining AES_SEQ_TIMEOUT_EN.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StWrite = 3'd4,
    StFin   = 3'd5
  } seq_state_e;

  localparam int unsigned RowW    = 32;
  localparam int unsigned NumRows = 4;
  localparam int unsigned BlockW  = RowW * NumRows;

  localparam int unsigned DefaultTimeoutCycles = 64;

  // Row 0 sits in the most significant word of a block.
  function automatic logic [RowW-1:0] block_row(input logic [BlockW-1:0] blk,
                                                input int unsigned idx);
    return blk[BlockW-1-idx*RowW -: RowW];
  endfunction

endpackage

// File: rtl/aes_seq_watchdog.sv
// Wait-cycle counter for the sequencer's core watchdog (used with AES_SEQ_TIMEOUT_EN).
// expired is high in the Limit-th consecutive enabled cycle after a clear.
module aes_seq_watchdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = en && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/aes_block_sequencer.sv
// Walks the AES core over a run of 128-bit blocks: fetch, issue, wait, write back.
// Define AES_SEQ_TIMEOUT_EN to add a watchdog on the core's done handshake.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned MAX_BLOCKS = 256,
  parameter int unsigned CNT_W      = $clog2(MAX_BLOCKS + 1)
`ifdef AES_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  input  logic [CNT_W-1:0]  blk_count,
  output logic              mem_ren,
  input  logic [RowW-1:0]   mem_row0,
  input  logic [RowW-1:0]   mem_row1,
  input  logic [RowW-1:0]   mem_row2,
  input  logic [RowW-1:0]   mem_row3,
  output logic              mem_wen,
  output logic [RowW-1:0]   mem_wrow0,
  output logic [RowW-1:0]   mem_wrow1,
  output logic [RowW-1:0]   mem_wrow2,
  output logic [RowW-1:0]   mem_wrow3,
  input  logic              core_ready,
  output logic              core_start,
  output logic [BlockW-1:0] core_din,
  input  logic              core_done,
  input  logic [BlockW-1:0] core_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  blocks_done
);

  seq_state_e        state_q;
  logic [BlockW-1:0] blk_q;
  logic [BlockW-1:0] res_q;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  blocks_done_q;
  logic [CNT_W-1:0]  blocks_inc;
  logic              count_ok;
  logic              busy_state;
  logic              timeout;

  assign busy_state = (state_q == StFetch) || (state_q == StIssue) ||
                      (state_q == StWait)  || (state_q == StWrite);
  assign count_ok   = (blk_count != '0) && (32'(blk_count) <= MAX_BLOCKS);
  assign blocks_inc = blocks_done_q + CNT_W'(1);

`ifdef AES_SEQ_TIMEOUT_EN
  logic err_q;

  aes_seq_watchdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q != StWait),
    .en     (state_q == StWait),
    .expired(timeout)
  );

  // A done arriving with the expiry wins, so no error is flagged then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && go && count_ok) begin
      err_q <= 1'b0;
    end else if (state_q == StWait && !abort && !core_done && timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      blk_q         <= '0;
      res_q         <= '0;
      target_q      <= '0;
      blocks_done_q <= '0;
    end else if (abort && busy_state) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            if (count_ok) begin
              target_q      <= blk_count;
              blocks_done_q <= '0;
              state_q       <= StFetch;
            end else begin
              state_q <= StFin;
            end
          end
        end
        StFetch: begin
          blk_q   <= {mem_row0, mem_row1, mem_row2, mem_row3};
          state_q <= StIssue;
        end
        StIssue: begin
          if (core_ready) state_q <= StWait;
        end
        StWait: begin
          if (core_done) begin
            res_q   <= core_dout;
            state_q <= StWrite;
          end else if (timeout) begin
            state_q <= StFin;
          end
        end
        StWrite: begin
          blocks_done_q <= blocks_inc;
          state_q       <= (blocks_inc == target_q) ? StFin : StFetch;
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_state;
  assign done        = (state_q == StFin);
  assign mem_ren     = (state_q == StFetch);
  assign mem_wen     = (state_q == StWrite) && !abort;
  assign core_start  = (state_q == StIssue) && core_ready && !abort;
  assign core_din    = blk_q;
  assign mem_wrow0   = block_row(res_q, 0);
  assign mem_wrow1   = block_row(res_q, 1);
  assign mem_wrow2   = block_row(res_q, 2);
  assign mem_wrow3   = block_row(res_q, 3);
  assign blocks_done = blocks_done_q;

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
- Sequences the AES datapath over a run of 128-bit blocks held in the 4-row block memory.
- Per block: fetches 4 rows, issues the block to the AES core, waits for the result, writes it back, and advances.
- Sits between top-level control (go/abort/status) and both the memory's read/write ports and the AES core's start/done handshake.

Parameters:
- MAX_BLOCKS, 256: largest run length accepted.
- CNT_W, $clog2(MAX_BLOCKS+1): width of block counters.
- TIMEOUT_CYCLES, 64: core watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start a run (single-cycle pulse)
- abort  in  1  synchronous abort of the current run
- blk_count  in  CNT_W  number of blocks in the run, sampled on go
- mem_ren  out  1  advance memory read pointer by 4 rows
- mem_row0..mem_row3  in  32 each  current 4 rows from memory (combinational)
- mem_wen  out  1  write strobe
- mem_wrow0..mem_wrow3  out  32 each  write data rows
- core_ready  in  1  AES core idle and able to accept a block
- core_start  out  1  one-cycle start pulse to the core
- core_din  out  128  block to the core: {row0,row1,row2,row3}, row0 at [127:96]
- core_done  in  1  one-cycle result-valid pulse from the core
- core_dout  in  128  core result, same row mapping as core_din
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- err  out  1  sticky watchdog error
- blocks_done  out  CNT_W  blocks written back in the current or last run

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; internal block/result registers 0; target 0.
- Priority each cycle: abort > everything else.
- States: IDLE, FETCH, ISSUE, WAIT, WRITE, FIN.
- IDLE
  - go=1 and blk_count in 1..MAX_BLOCKS: latch target, clear blocks_done and err, busy=1, go to FETCH.
  - go=1 and blk_count=0 or blk_count>MAX_BLOCKS: go to FIN directly; nothing else changes.
- FETCH (exactly 1 cycle): capture mem_row0..3 into blk_reg; mem_ren=1 this cycle only; go to ISSUE.
- ISSUE
  - Wait for core_ready=1.
  - In the cycle core_ready=1: core_start=1 and core_din=blk_reg; go to WAIT.
  - core_din holds blk_reg in every state; it is meaningful only with core_start.
- WAIT: on core_done=1, capture core_dout into res_reg; go to WRITE.
- core_done outside WAIT is ignored.
- WRITE (exactly 1 cycle)
  - mem_wen=1; mem_wrow0..3 = res_reg rows; blocks_done increments this edge.
  - If the new blocks_done equals target, go to FIN; otherwise go to FETCH.
- FIN (1 cycle): done=1, busy=0; go to IDLE.
- busy=1 in FETCH, ISSUE, WAIT, WRITE; 0 in IDLE and FIN.
- go while busy=1 is ignored.
- go arriving in the FIN cycle is ignored; go is accepted only in IDLE.
- abort=1 in any busy state:
  - Next state IDLE, busy=0.
  - No done pulse; mem_wen and core_start are forced 0 in the abort cycle.
  - blocks_done retains its value.
  - The memory pointer is not rewound.
- Per-block latency, core latency L cycles from start to done, core_ready already high: FETCH 1 + ISSUE 1 + L + WRITE 1.
- The first mem_ren occurs the cycle after go.
- Counter arithmetic is unsigned CNT_W bits; blocks_done never exceeds target, so there is no wrap.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_done: err=1 (sticky until the next accepted go), go to FIN, and done pulses.
  - core_done in the same cycle as the timeout wins; no error is raised.
- Undefined: err is tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package aes_seq_pkg:
  - State encodings: IDLE=0, FETCH=1, ISSUE=2, WAIT=3, WRITE=4, FIN=5.
  - Row-to-bit mapping constants for the 128-bit block.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, aes_seq_watchdog: clear/enable/expired counter, instantiated only under AES_SEQ_TIMEOUT_EN.

Test Plan:
1. Reset mid-run (rst_n low during WAIT) -> all outputs 0 immediately, state IDLE, and a new go starts cleanly.
2. blk_count=3, core_ready=1, core L=4, rows 0x00112233/44556677/8899AABB/CCDDEEFF -> core_din=0x00112233445566778899AABBCCDDEEFF; per-block pattern 1 FETCH + 1 ISSUE + 4 WAIT + 1 WRITE; 3 mem_ren, 3 mem_wen; done pulse 1 cycle after the 3rd mem_wen; blocks_done=3.
3. core_ready held low 5 cycles in ISSUE -> core_start asserted only in the cycle core_ready rises; no extra mem_ren.
4. go with blk_count=0 -> done pulses 1 cycle later; no mem_ren, no mem_wen; busy stays 0.
5. abort asserted in the same cycle core_done arrives -> no mem_wen; next cycle IDLE; no done pulse; blocks_done unchanged.
6. AES_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never done -> err=1 and done pulse after 8 WAIT cycles; err clears on the next go.
